mvu_pe_adder_tree_pipe: RTL and testbench
=========================================

# mvu_pe_adder_tree_pipe

Parametrised, pipelined adder tree that reduces the SIMD lane products of one processing element to a single sum per cycle. It is the next-generation PE reduction stage. It adds lossless width growth, selectable signed/unsigned extension, configurable register insertion between tree levels, a valid/last sideband that travels with the data, and a global stall enable so the downstream accumulator can apply backpressure. It sits between the PE SIMD multipliers and the PE accumulator inside the MVU stream unit.

## Interface
Parameters:
- SIMD, 2: number of input lanes; must be ≥1; non-power-of-two is allowed.
- TDstI, 16: input lane width in bits.
- SIGNED, 1: 1 sign-extends at every level; 0 zero-extends.
- PIPE_EVERY, 1: a register bank is inserted after every PIPE_EVERY tree levels; must be ≥1.
- LVL (derived), ceil(log2(SIMD)): number of tree levels; 0 when SIMD=1.
- OUT_W (derived), TDstI+LVL: output width.
- LAT (derived), max(1, ceil(LVL/PIPE_EVERY)): latency in enabled cycles.

Ports:
- aclk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset; synchronous, active-high.
- en, in, 1: pipeline advance enable; when 0, every register holds.
- in_valid, in, 1: in_simd is valid this cycle.
- in_last, in, 1: sideband tag; marks the final SIMD fold of a row.
- in_simd, in, TDstI × [0:SIMD-1]: lane operands.
- out_valid, out, 1: out_add is valid.
- out_last, out, 1: in_last delayed by LAT.
- out_add, out, OUT_W: sum of all lanes, with no truncation.

## Operation
- Level k (1..LVL) takes N(k-1) operands of width TDstI+k-1, where N(0)=SIMD.
  - It pairs operands 2i and 2i+1 and outputs ceil(N(k-1)/2) operands of width TDstI+k.
  - An odd trailing operand passes through unchanged, width-extended only.
- Extension: each operand is extended by 1 bit before adding.
  - SIGNED=1: replicate the MSB.
  - SIGNED=0: prepend 0.
- Because each level adds exactly one bit, overflow is impossible and out_add is exact modulo nothing.
- Register banks:
  - A bank follows level j when j mod PIPE_EVERY = 0, and after level LVL.
  - The bank after level LVL is never duplicated: the final level is registered exactly once.
  - For SIMD=1 the single bank holds the extended-free input, so OUT_W=TDstI.
- Each bank carries data, valid and last.
- Data registers load regardless of valid when en=1. Only out_valid qualifies out_add.
- en=0: all banks, including valid and last, hold their value. in_valid and in_last presented during a stall are ignored (not captured).

## Timing
- Latency: with en held at 1, inputs sampled at edge t appear on out_add/out_valid/out_last after edge t+LAT-1, and are visible in the cycle following edge t+LAT-1.
- Stalls extend latency by the number of en=0 cycles; no data is lost or duplicated.
- Throughput: one result per enabled cycle.
- Reset: every bank clears its data to 0 and its valid and last to 0, so out_add=0, out_valid=0 and out_last=0.
  - Reset takes priority over en.
  - Asserting rst mid-stream discards all in-flight sums.
  - The first valid output after reset release appears LAT enabled cycles after the first captured in_valid.
- rst and en=0 asserted together: reset wins.
- Back-to-back valid inputs with an alternating in_last: out_last alternates identically, aligned to its own sum.

## Structure
- Shared package mvu_pkg holds:
  - function clog2;
  - function num_levels(SIMD);
  - function lanes_at_level(SIMD, k);
  - function is_reg_level(k, LVL, PIPE_EVERY).
- Sub-module mvu_pe_add_level is one tree level.
  - Parameters: N_IN, W_IN, SIGNED, REG.
  - It does the extend, pairwise add and odd pass-through, plus an optional register bank with valid/last and en/rst.
- The top is a generate loop over levels that chains mvu_pe_add_level instances. It targets roughly 150–250 lines of RTL total.

## Test plan
- SIMD=4, TDstI=8, SIGNED=1, PIPE_EVERY=1, so LAT=2. Lanes {127,127,127,127} → out_add=508 (10 bits), two cycles later with out_valid=1. Lanes {-128×4} → out_add=-512.
- SIMD=5, SIGNED=0, TDstI=4, so LVL=3 and OUT_W=7. Lanes {15,15,15,15,15} → out_add=75. This checks the odd pass-through.
- SIMD=8, PIPE_EVERY=2, so LAT=2. Stream 100 random valid vectors with en=1 → exact match against a reference sum, and out_last aligned.
- Random en deassertion (about 30%) during the stream → same result sequence, no drops or duplicates, and outputs held stable while en=0.
- Assert rst for 1 cycle with 2 results in flight → out_valid=0 and out_add=0 the next cycle, and no stale result emerges afterwards.
- SIMD=1, TDstI=8 → out_add equals the input after 1 cycle, with OUT_W=8.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared helpers for the MVU PE reduction tree: level counts, lane counts per
// level and register-bank placement.
package mvu_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    function automatic int unsigned num_levels(input int unsigned simd);
        return clog2(simd);
    endfunction

    // Operands remaining after k levels of pairwise reduction.
    function automatic int unsigned lanes_at_level(input int unsigned simd, input int unsigned k);
        int unsigned n = simd;
        for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // The last level is always registered, exactly once.
    function automatic bit is_reg_level(input int unsigned k, input int unsigned lvl,
                                        input int unsigned pipe_every);
        return (k >= lvl) || ((k % pipe_every) == 0);
    endfunction

endpackage

// File: rtl/mvu_pe_add_level.sv
// One adder-tree level: extend by one bit, pairwise add, pass an odd trailing
// operand through, and optionally register data/valid/last.
module mvu_pe_add_level
    import mvu_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned W_IN   = 16,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned REG    = 1,
    localparam int unsigned N_OUT = (N_IN + 1) / 2,
    localparam int unsigned W_OUT = (N_IN > 1) ? W_IN + 1 : W_IN
) (
    input  logic                          aclk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [0:N_IN-1][W_IN-1:0]     in_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [0:N_OUT-1][W_OUT-1:0]   out_data
);

    logic [0:N_OUT-1][W_OUT-1:0] sum;

    function automatic logic [W_OUT-1:0] ext(input logic [W_IN-1:0] v);
        if (SIGNED != 0) return W_OUT'(signed'(v));
        return W_OUT'(v);
    endfunction

    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        if (2 * i + 1 < N_IN) begin : g_add
            assign sum[i] = ext(in_data[2*i]) + ext(in_data[2*i+1]);
        end else begin : g_odd
            assign sum[i] = ext(in_data[2*i]);
        end
    end

    if (REG != 0) begin : g_reg
        logic [0:N_OUT-1][W_OUT-1:0] data_d, data_q;
        logic                        valid_d, valid_q;
        logic                        last_d, last_q;

        // Data loads regardless of valid; only valid qualifies it downstream.
        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            last_d  = last_q;
            if (en) begin
                data_d  = sum;
                valid_d = in_valid;
                last_d  = in_last;
            end
        end

        always_ff @(posedge aclk) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
                last_q  <= last_d;
            end
        end

        assign out_data  = data_q;
        assign out_valid = valid_q;
        assign out_last  = last_q;
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{aclk, rst, en};
        assign out_data    = sum;
        assign out_valid   = in_valid;
        assign out_last    = in_last;
    end

endmodule

// File: rtl/mvu_pe_adder_tree_pipe.sv
// Pipelined lossless adder tree reducing SIMD lane products to one sum per
// enabled cycle, with valid/last sideband and a global stall enable.
module mvu_pe_adder_tree_pipe
    import mvu_pkg::*;
#(
    parameter int unsigned SIMD       = 2,
    parameter int unsigned TDstI      = 16,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned PIPE_EVERY = 1,
    localparam int unsigned OUT_W     = TDstI + num_levels(SIMD)
) (
    input  logic                         aclk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [0:SIMD-1][TDstI-1:0]   in_simd,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [OUT_W-1:0]             out_add
);

    localparam int unsigned LVL   = num_levels(SIMD);
    // SIMD=1 still needs one (width-preserving) registered stage.
    localparam int unsigned NINST = (LVL == 0) ? 1 : LVL;

    for (genvar k = 1; k <= NINST; k++) begin : g_lvl
        localparam int unsigned N_IN  = lanes_at_level(SIMD, k - 1);
        localparam int unsigned W_IN  = TDstI + k - 1;
        localparam int unsigned N_OUT = (N_IN + 1) / 2;
        localparam int unsigned W_OUT = (N_IN > 1) ? W_IN + 1 : W_IN;
        localparam int unsigned REG   = is_reg_level(k, LVL, PIPE_EVERY) ? 1 : 0;

        logic [0:N_IN-1][W_IN-1:0]   din;
        logic                        vin, lin;
        logic [0:N_OUT-1][W_OUT-1:0] dout;
        logic                        vout, lout;

        if (k == 1) begin : g_src
            assign din = in_simd;
            assign vin = in_valid;
            assign lin = in_last;
        end else begin : g_chain
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign lin = g_lvl[k-1].lout;
        end

        mvu_pe_add_level #(
            .N_IN   (N_IN),
            .W_IN   (W_IN),
            .SIGNED (SIGNED),
            .REG    (REG)
        ) u_level (
            .aclk      (aclk),
            .rst       (rst),
            .en        (en),
            .in_valid  (vin),
            .in_last   (lin),
            .in_data   (din),
            .out_valid (vout),
            .out_last  (lout),
            .out_data  (dout)
        );
    end

    assign out_add   = g_lvl[NINST].dout[0];
    assign out_valid = g_lvl[NINST].vout;
    assign out_last  = g_lvl[NINST].lout;

endmodule

// File: tb/tb_mvu_pe_adder_tree_pipe.sv
// Scoreboard bench: four tree configurations share control, each checked against
// a plain integer lane-sum model with enabled-cycle latency tracking.
module tb_mvu_pe_adder_tree_pipe;

    typedef struct {
        logic [15:0] d;
        bit          l;
        int unsigned tag;
    } exp_t;

    // Instances: A(4x8 signed, P1), B(5x4 unsigned, P1), C(8x8 signed, P2), D(1x8 signed)
    localparam int LANES [4] = '{4, 5, 8, 1};
    localparam int WID   [4] = '{8, 4, 8, 8};
    localparam int SGN   [4] = '{1, 0, 1, 1};
    localparam int OW    [4] = '{10, 7, 11, 8};
    localparam int LAT   [4] = '{2, 3, 2, 1};

    logic aclk, rst, en, in_valid, in_last;
    logic [0:3][7:0] in_a;
    logic [0:4][3:0] in_b;
    logic [0:7][7:0] in_c;
    logic [0:0][7:0] in_d;
    logic [9:0]  out_a;
    logic [6:0]  out_b;
    logic [10:0] out_c;
    logic [7:0]  out_d;
    logic ov_a, ov_b, ov_c, ov_d, ol_a, ol_b, ol_c, ol_d;

    logic [15:0] lane [4][8];
    exp_t q_a[$], q_b[$], q_c[$], q_d[$];
    int unsigned ecnt = 0;
    int checks = 0, errors = 0;
    logic [17:0] prev [4];

    mvu_pe_adder_tree_pipe #(.SIMD(4), .TDstI(8), .SIGNED(1), .PIPE_EVERY(1)) u_a (
        .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_simd(in_a), .out_valid(ov_a), .out_last(ol_a), .out_add(out_a));
    mvu_pe_adder_tree_pipe #(.SIMD(5), .TDstI(4), .SIGNED(0), .PIPE_EVERY(1)) u_b (
        .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_simd(in_b), .out_valid(ov_b), .out_last(ol_b), .out_add(out_b));
    mvu_pe_adder_tree_pipe #(.SIMD(8), .TDstI(8), .SIGNED(1), .PIPE_EVERY(2)) u_c (
        .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_simd(in_c), .out_valid(ov_c), .out_last(ol_c), .out_add(out_c));
    mvu_pe_adder_tree_pipe #(.SIMD(1), .TDstI(8), .SIGNED(1), .PIPE_EVERY(1)) u_d (
        .aclk(aclk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_simd(in_d), .out_valid(ov_d), .out_last(ol_d), .out_add(out_d));

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) if (!rst && en) ecnt <= ecnt + 1;

    function automatic int lane_val(input logic [15:0] x, input int w, input int sgn);
        int v;
        v = int'(x) & ((1 << w) - 1);
        if (sgn != 0 && v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0: return q_a.size();
            1: return q_b.size();
            2: return q_c.size();
            default: return q_d.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int idx);
        case (idx)
            0: return q_a[0];
            1: return q_b[0];
            2: return q_c[0];
            default: return q_d[0];
        endcase
    endfunction

    function automatic exp_t qpop(input int idx);
        case (idx)
            0: return q_a.pop_front();
            1: return q_b.pop_front();
            2: return q_c.pop_front();
            default: return q_d.pop_front();
        endcase
    endfunction

    task automatic chk(input bit ok, input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s[inst %0d] t=%0t: got 0x%0h, expected 0x%0h",
                     name, idx, $time, act, req);
        end
    endtask

    task automatic push(input int idx, input bit l);
        exp_t x;
        int s;
        s = 0;
        for (int i = 0; i < LANES[idx]; i++) s += lane_val(lane[idx][i], WID[idx], SGN[idx]);
        x.d   = 16'(s & ((1 << OW[idx]) - 1));
        x.l   = l;
        x.tag = ecnt + 1;
        case (idx)
            0: q_a.push_back(x);
            1: q_b.push_back(x);
            2: q_c.push_back(x);
            default: q_d.push_back(x);
        endcase
    endtask

    task automatic rand_data();
        for (int idx = 0; idx < 4; idx++)
            for (int i = 0; i < 8; i++)
                lane[idx][i] = 16'($urandom) & 16'((1 << WID[idx]) - 1);
    endtask

    task automatic drive(input bit e, input bit r, input bit v, input bit l);
        en = e; rst = r; in_valid = v; in_last = l;
        for (int i = 0; i < 4; i++) in_a[i] = lane[0][i][7:0];
        for (int i = 0; i < 5; i++) in_b[i] = lane[1][i][3:0];
        for (int i = 0; i < 8; i++) in_c[i] = lane[2][i][7:0];
        in_d[0] = lane[3][0][7:0];
        if (r) begin
            q_a.delete(); q_b.delete(); q_c.delete(); q_d.delete();
        end else if (e && v) begin
            for (int idx = 0; idx < 4; idx++) push(idx, l);
        end
    endtask

    task automatic mon(input int idx, input bit r_s, input bit e_s,
                       input logic [15:0] d, input bit v, input bit l);
        exp_t x;
        logic [17:0] act;
        act = {v, l, d};
        if (r_s) begin
            chk(act == 18'd0, idx, "reset_clear", 32'(act), 32'd0);
        end else if (!e_s) begin
            chk(act == prev[idx], idx, "stall_hold", 32'(act), 32'(prev[idx]));
        end else if (v) begin
            if (qsize(idx) == 0) begin
                chk(1'b0, idx, "unexpected_output", 32'(act), 32'd0);
            end else begin
                x = qpop(idx);
                chk(d == x.d, idx, "sum", 32'(d), 32'(x.d));
                chk(l == x.l, idx, "last", 32'(l), 32'(x.l));
                chk(ecnt == x.tag + LAT[idx] - 1, idx, "latency", ecnt, x.tag + LAT[idx] - 1);
            end
        end else if (qsize(idx) > 0) begin
            x = qfront(idx);
            if (x.tag + LAT[idx] - 1 <= ecnt)
                chk(1'b0, idx, "missing_output", 32'(act), 32'(x.d));
        end
        prev[idx] = act;
    endtask

    always @(posedge aclk) begin : p_mon
        bit r_s, e_s;
        r_s = rst;
        e_s = en;
        #1;
        mon(0, r_s, e_s, 16'(out_a), ov_a, ol_a);
        mon(1, r_s, e_s, 16'(out_b), ov_b, ol_b);
        mon(2, r_s, e_s, 16'(out_c), ov_c, ol_c);
        mon(3, r_s, e_s, 16'(out_d), ov_d, ol_d);
    end

    initial begin
        for (int i = 0; i < 4; i++) prev[i] = '0;
        for (int idx = 0; idx < 4; idx++)
            for (int i = 0; i < 8; i++) lane[idx][i] = '0;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge aclk); rand_data(); drive(1'b0, 1'b1, 1'b1, 1'b1);
        end
        // Directed extremes: 4x127, 4x-128, 5x15.
        @(negedge aclk); rand_data();
        for (int i = 0; i < 8; i++) begin lane[0][i] = 16'd127; lane[1][i] = 16'd15; end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge aclk); rand_data();
        for (int i = 0; i < 8; i++) begin lane[0][i] = 16'h80; lane[1][i] = 16'd15; end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        // Back-to-back stream with alternating last.
        for (int n = 0; n < 100; n++) begin
            @(negedge aclk); rand_data(); drive(1'b1, 1'b0, 1'b1, n[0]);
        end
        // Random stalls (~30%) and gaps.
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk); rand_data();
            drive(1'($urandom_range(0, 9) >= 3), 1'b0, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end
        // Reset with results in flight; inputs during reset are discarded.
        @(negedge aclk); rand_data(); drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge aclk); rand_data(); drive(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge aclk); rand_data(); drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 40; n++) begin
            @(negedge aclk); rand_data();
            drive(1'($urandom_range(0, 9) >= 2), 1'b0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        repeat (10) begin
            @(negedge aclk); drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
        @(negedge aclk);
        for (int idx = 0; idx < 4; idx++)
            chk(qsize(idx) == 0, idx, "drained", 32'(qsize(idx)), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
